// File: rtl/mira_2d.sv
// Movable crosshair cursor with a registered overlay pixel.
// Ports: clk, nrst, frame_start, move_en, en_x, en_y, rightleft, updown,
//        wrap_mode, recenter, row, column in; cx, cy, s out.
module mira_2d #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int W     = 10,
  parameter int STEP  = 1,
  parameter int DIV   = 1,
  parameter int ARM   = 15,
  parameter int THICK = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         frame_start,
  input  logic         move_en,
  input  logic         en_x,
  input  logic         en_y,
  input  logic         rightleft,
  input  logic         updown,
  input  logic         wrap_mode,
  input  logic         recenter,
  input  logic [W-1:0] row,
  input  logic [W-1:0] column,
  output logic [W-1:0] cx,
  output logic [W-1:0] cy,
  output logic         s
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  localparam logic [W:0] HR  = (W+1)'(H_RES);
  localparam logic [W:0] VR  = (W+1)'(V_RES);
  localparam logic [W:0] STP = (W+1)'(STEP);
  localparam logic [W:0] ARW = (W+1)'(ARM);
  localparam logic [W:0] THK = (W+1)'(THICK);

  localparam logic [W-1:0] CX0 = W'(H_RES / 2);
  localparam logic [W-1:0] CY0 = W'(V_RES / 2);

  logic [PW-1:0] pre;
  logic          mv;
  logic [W-1:0]  nx;
  logic [W-1:0]  ny;
  logic [W:0]    dx;
  logic [W:0]    dy;
  logic          hit;

  // One axis step; W+1 bits hold cx+STEP and cx+res-STEP without overflow.
  function automatic logic [W-1:0] nxt(
    input logic [W-1:0] p,
    input logic         inc,
    input logic         wrap,
    input logic [W:0]   res
  );
    logic [W:0] pe;
    logic [W:0] up;
    logic [W:0] r;
    pe = {1'b0, p};
    up = pe + STP;
    if (inc) begin
      if (up <= res - 1'b1)
        r = up;
      else
        r = wrap ? up - res : res - 1'b1;
    end else begin
      if (pe >= STP)
        r = pe - STP;
      else
        r = wrap ? pe + res - STP : '0;
    end
    return r[W-1:0];
  endfunction

  assign mv = frame_start & move_en & (pre == PMAX);
  assign nx = nxt(cx, rightleft, wrap_mode, HR);
  assign ny = nxt(cy, updown, wrap_mode, VR);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pre <= '0;
    end else if (recenter || !move_en) begin
      pre <= '0;
    end else if (frame_start) begin
      pre <= (pre == PMAX) ? '0 : pre + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst || recenter) begin
      cx <= CX0;
      cy <= CY0;
    end else if (mv) begin
      if (en_x) cx <= nx;
      if (en_y) cy <= ny;
    end
  end

  // Absolute coordinates: arm pixels past an edge never match a beam position.
  always_comb begin
    logic [W:0] ce;
    logic [W:0] re;
    logic [W:0] xe;
    logic [W:0] ye;
    ce  = {1'b0, column};
    re  = {1'b0, row};
    xe  = {1'b0, cx};
    ye  = {1'b0, cy};
    dx  = (ce >= xe) ? ce - xe : xe - ce;
    dy  = (re >= ye) ? re - ye : ye - re;
    hit = ((dx <= ARW) && (dy <= THK)) ||
          ((dy <= ARW) && (dx <= THK));
  end

  always_ff @(posedge clk) begin
    if (!nrst)
      s <= 1'b0;
    else
      s <= hit;
  end

endmodule

// File: tb/tb_mira_2d.sv
// Scoreboard bench for mira_2d: two instances (DIV=4/STEP=2, DIV=1/STEP=3)
// share stimulus; a frame-counting reference model predicts each cycle.
module tb_mira_2d;

  logic clk = 1'b0;
  logic nrst, frame_start, move_en, en_x, en_y;
  logic rightleft, updown, wrap_mode, recenter;
  logic [9:0] row, column;
  logic [9:0] cxa, cya, cxb, cyb;
  logic sa, sb;

  always #5 clk = ~clk;

  mira_2d #(.STEP(2), .DIV(4)) u0 (
    .clk(clk), .nrst(nrst), .frame_start(frame_start),
    .move_en(move_en), .en_x(en_x), .en_y(en_y),
    .rightleft(rightleft), .updown(updown), .wrap_mode(wrap_mode),
    .recenter(recenter), .row(row), .column(column),
    .cx(cxa), .cy(cya), .s(sa)
  );

  mira_2d #(.STEP(3), .DIV(1)) u1 (
    .clk(clk), .nrst(nrst), .frame_start(frame_start),
    .move_en(move_en), .en_x(en_x), .en_y(en_y),
    .rightleft(rightleft), .updown(updown), .wrap_mode(wrap_mode),
    .recenter(recenter), .row(row), .column(column),
    .cx(cxb), .cy(cyb), .s(sb)
  );

  typedef struct packed {
    logic [9:0] x0, y0, x1, y1;
    logic s0, s1;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  bit done = 0;

  int stp[2] = '{2, 3};
  int dv[2]  = '{4, 1};
  int mcx[2], mcy[2], mcnt[2];

  function automatic int pix(int x, int y, int r, int c);
    int dx, dy;
    dx = (c > x) ? c - x : x - c;
    dy = (r > y) ? r - y : y - r;
    return ((dx <= 15 && dy <= 1) || (dy <= 15 && dx <= 1)) ? 1 : 0;
  endfunction

  function automatic int step1(int p, bit inc, bit wrap, int res, int st);
    if (wrap)
      return inc ? (p + st) % res : (p - st + res) % res;
    if (inc)
      return (p + st > res - 1) ? res - 1 : p + st;
    return (p - st < 0) ? 0 : p - st;
  endfunction

  // Predict the state after the coming edge, push it, wait to next negedge.
  task automatic tick();
    int nx[2], ny[2], ns[2];
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      ns[i] = pix(mcx[i], mcy[i], int'(row), int'(column));
      if (!nrst) begin
        mcx[i] = 320; mcy[i] = 240; mcnt[i] = 0; ns[i] = 0;
      end else if (recenter) begin
        mcx[i] = 320; mcy[i] = 240; mcnt[i] = 0;
      end else if (!move_en) begin
        mcnt[i] = 0;
      end else if (frame_start) begin
        mcnt[i]++;
        if (mcnt[i] == dv[i]) begin
          mcnt[i] = 0;
          if (en_x) mcx[i] = step1(mcx[i], rightleft, wrap_mode, 640, stp[i]);
          if (en_y) mcy[i] = step1(mcy[i], updown, wrap_mode, 480, stp[i]);
        end
      end
      nx[i] = mcx[i];
      ny[i] = mcy[i];
    end
    e.x0 = 10'(nx[0]); e.y0 = 10'(ny[0]); e.s0 = ns[0][0];
    e.x1 = 10'(nx[1]); e.y1 = 10'(ny[1]); e.s1 = ns[1][0];
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic frames(int n);
    for (int k = 0; k < n; k++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("u0.cx", int'(cxa), int'(e.x0));
        chk("u0.cy", int'(cya), int'(e.y0));
        chk("u0.s", int'(sa), int'(e.s0));
        chk("u1.cx", int'(cxb), int'(e.x1));
        chk("u1.cy", int'(cyb), int'(e.y1));
        chk("u1.s", int'(sb), int'(e.s1));
      end
    end
  end

  initial begin : stim
    int pick, c, r;
    nrst = 1'b0; frame_start = 1'b0; move_en = 1'b0;
    en_x = 1'b0; en_y = 1'b0; rightleft = 1'b0; updown = 1'b0;
    wrap_mode = 1'b0; recenter = 1'b1;
    frame_start = 1'b1;
    row = 10'd240; column = 10'd335;
    @(negedge clk);
    tick();
    recenter = 1'b0; frame_start = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    column = 10'd336;
    tick();
    tick();

    move_en = 1'b1; en_x = 1'b1; rightleft = 1'b1;
    frames(8);

    recenter = 1'b1; frame_start = 1'b1;
    tick();
    recenter = 1'b0; frame_start = 1'b0;
    tick();

    wrap_mode = 1'b1; rightleft = 1'b1;
    frames(106);
    frames(1);
    rightleft = 1'b0;
    frames(2);

    recenter = 1'b1; tick(); recenter = 1'b0;
    wrap_mode = 1'b0; en_x = 1'b0; en_y = 1'b1; updown = 1'b0;
    frames(82);

    recenter = 1'b1; tick(); recenter = 1'b0;
    en_x = 1'b1; en_y = 1'b0; rightleft = 1'b0;
    frames(105);
    row = 10'd240; column = 10'd0;
    tick(); tick();
    column = 10'd639;
    tick(); tick();

    frame_start = 1'b1; recenter = 1'b1; nrst = 1'b0;
    tick();
    frame_start = 1'b0; recenter = 1'b0; nrst = 1'b1;
    tick();

    for (int k = 0; k < 1500; k++) begin
      frame_start = ($urandom_range(0, 2) == 0);
      move_en     = ($urandom_range(0, 7) != 0);
      en_x        = $urandom_range(0, 1) == 1;
      en_y        = $urandom_range(0, 1) == 1;
      rightleft   = $urandom_range(0, 1) == 1;
      updown      = $urandom_range(0, 1) == 1;
      wrap_mode   = $urandom_range(0, 1) == 1;
      recenter    = ($urandom_range(0, 39) == 0);
      nrst        = ($urandom_range(0, 99) != 0);
      pick = $urandom_range(0, 2);
      if (pick == 2) begin
        c = $urandom_range(0, 1023);
        r = $urandom_range(0, 1023);
      end else begin
        c = mcx[pick] + $urandom_range(0, 40) - 20;
        r = mcy[pick] + $urandom_range(0, 40) - 20;
        if (c < 0) c = 0;
        if (r < 0) r = 0;
      end
      column = 10'(c);
      row = 10'(r);
      tick();
    end

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
